// File: rtl/butterfly_r2_cfg_if.sv
// butterfly_r2_cfg_if: sample, mode and result signals of the radix-2 butterfly
interface butterfly_r2_cfg_if #(parameter int DW = 16, parameter int TW = 16);
  logic in_vld, scale, inv, ovf_clr, out_vld, ovf;
  logic signed [DW-1:0] xp_re, xp_im, xq_re, xq_im;
  logic signed [TW-1:0] w_re, w_im;
  logic signed [DW-1:0] yp_re, yp_im, yq_re, yq_im;
  modport master (
    output in_vld, scale, inv, ovf_clr, xp_re, xp_im, xq_re, xq_im, w_re, w_im,
    input  out_vld, ovf, yp_re, yp_im, yq_re, yq_im
  );
  modport slave (
    input  in_vld, scale, inv, ovf_clr, xp_re, xp_im, xq_re, xq_im, w_re, w_im,
    output out_vld, ovf, yp_re, yp_im, yq_re, yq_im
  );
endinterface

// File: rtl/butterfly_r2_cfg.sv
// butterfly_r2_cfg: 3-stage radix-2 DIT butterfly with scaling, conjugate twiddle, rounding and saturation
module butterfly_r2_cfg #(
  parameter int DW = 16,
  parameter int TW = 16,
  parameter bit SAT_EN = 1
) (
  input logic clk,
  input logic rst,
  butterfly_r2_cfg_if.slave bus
);
  localparam int MW = DW + TW + 1;
  localparam int AW = DW + TW - 1;
  localparam int PW = DW + TW + 2;
  localparam int SW = DW + TW + 3;
  localparam logic signed [SW-1:0] MAXV = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = ~MAXV;
  localparam logic signed [SW-1:0] RH0 = {{(SW-1){1'b0}}, 1'b1} << (TW-2);
  localparam logic signed [SW-1:0] RH1 = {{(SW-1){1'b0}}, 1'b1} << (TW-1);
  logic v1, v2, sc1, sc2;
  logic signed [TW:0] wr, wi;
  logic signed [MW-1:0] m_rr, m_ii, m_ri, m_ir;
  logic signed [AW-1:0] ar1, ai1, ar2, ai2;
  logic signed [PW-1:0] pr2, pi2;
  logic signed [SW-1:0] sp_r, sp_i, sq_r, sq_i;
  logic [DW:0] fp_r, fp_i, fq_r, fq_i;
  // returns {out_of_range, final DW-bit value}
  function automatic logic [DW:0] fin(input logic signed [SW-1:0] s, input logic sc);
    logic signed [SW-1:0] r;
    logic hi, lo;
    r = (s + (sc ? RH1 : RH0)) >>> (sc ? TW : TW - 1);
    hi = r > MAXV;
    lo = r < MINV;
    return {hi | lo, (SAT_EN && hi) ? MAXV[DW-1:0] : (SAT_EN && lo) ? MINV[DW-1:0] : r[DW-1:0]};
  endfunction
  always_comb begin
    wr = (TW+1)'(bus.w_re);
    wi = bus.inv ? -(TW+1)'(bus.w_im) : (TW+1)'(bus.w_im);
    sp_r = SW'(ar2) + SW'(pr2);
    sq_r = SW'(ar2) - SW'(pr2);
    sp_i = SW'(ai2) + SW'(pi2);
    sq_i = SW'(ai2) - SW'(pi2);
    fp_r = fin(sp_r, sc2);
    fp_i = fin(sp_i, sc2);
    fq_r = fin(sq_r, sc2);
    fq_i = fin(sq_i, sc2);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {v1, v2, sc1, sc2} <= '0;
      {m_rr, m_ii, m_ri, m_ir} <= '0;
      {ar1, ai1, ar2, ai2, pr2, pi2} <= '0;
      bus.out_vld <= 1'b0;
      bus.ovf <= 1'b0;
      {bus.yp_re, bus.yp_im, bus.yq_re, bus.yq_im} <= '0;
    end else begin
      v1 <= bus.in_vld;
      v2 <= v1;
      bus.out_vld <= v2;
      bus.ovf <= (v2 & (fp_r[DW] | fp_i[DW] | fq_r[DW] | fq_i[DW])) | (bus.ovf & ~bus.ovf_clr);
      if (bus.in_vld) begin
        sc1 <= bus.scale;
        m_rr <= MW'(bus.xq_re) * MW'(wr);
        m_ii <= MW'(bus.xq_im) * MW'(wi);
        m_ri <= MW'(bus.xq_re) * MW'(wi);
        m_ir <= MW'(bus.xq_im) * MW'(wr);
        ar1 <= {bus.xp_re, {(TW-1){1'b0}}};
        ai1 <= {bus.xp_im, {(TW-1){1'b0}}};
      end
      if (v1) begin
        sc2 <= sc1;
        pr2 <= PW'(m_rr) - PW'(m_ii);
        pi2 <= PW'(m_ri) + PW'(m_ir);
        ar2 <= ar1;
        ai2 <= ai1;
      end
      if (v2) begin
        bus.yp_re <= fp_r[DW-1:0];
        bus.yp_im <= fp_i[DW-1:0];
        bus.yq_re <= fq_r[DW-1:0];
        bus.yq_im <= fq_i[DW-1:0];
      end
    end
  end
endmodule

// File: doc/butterfly_r2_cfg.md
Name: butterfly_r2_cfg

Overview:
- Parametrised radix-2 DIT butterfly for the fft_256 datapath; next generation of the fixed 16-bit butterfly.
- Computes yp = xp + xq*W and yq = xp - xq*W.
- Adds configurable data/twiddle widths, per-sample 1/2 scaling, inverse (conjugate-twiddle) mode, round-half-up, output saturation and a sticky overflow flag.
- Fully pipelined: accepts one sample per cycle with fixed latency.

Parameters:
- DW, 16: data width of xp/xq/yp/yq, signed two's complement.
- TW, 16: twiddle width, signed Q1.(TW-1); -1.0 (min code) allowed, +1.0 not representable.
- SAT_EN, 1: 1 saturates outputs to DW bits; 0 wraps (truncates MSBs).

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- in_vld  in  1  input sample valid
- scale  in  1  1 = divide result by 2 (stage scaling), sampled with in_vld
- inv  in  1  1 = use conj(W) (IFFT), sampled with in_vld
- xp_re, xp_im  in  DW  upper input, signed
- xq_re, xq_im  in  DW  lower input, signed
- w_re, w_im  in  TW  twiddle, signed Q1.(TW-1)
- ovf_clr  in  1  clears the sticky overflow flag
- out_vld  out  1  output valid
- yp_re, yp_im, yq_re, yq_im  out  DW  results, signed
- ovf  out  1  sticky overflow (saturation/wrap event)

Behaviour:
- Reset:
  - Asynchronous reset, active-high: clk is the single clock; rst is asynchronous and active-high.
  - While rst = 1: all pipeline registers, out_vld, y* outputs and ovf are 0.
  - An in-flight sample is discarded; no out_vld is produced for it after release.
- Pipeline:
  - Latency 3: in_vld at edge N gives out_vld = 1 after edge N+3.
  - Throughput 1 sample/cycle; no backpressure.
  - Each stage register loads only when its valid bit is 1; otherwise it holds.
  - Outputs hold their last value while out_vld = 0.
- Mode bits: scale and inv travel with their sample through the pipe. Changing them between consecutive samples must not affect samples already in flight.
- Stage 1:
  - Wi_eff = inv ? -w_im : w_im, computed at width TW+1 so -(-1.0) does not overflow.
  - Register the four products xq_re*w_re, xq_im*Wi_eff, xq_re*Wi_eff, xq_im*w_re, each DW+TW+1 bits.
  - Register xp left-aligned: xp << (TW-1), sign-extended.
- Stage 2: pr = re products difference, pi = im products sum (DW+TW+2 bits). xp passes through.
- Stage 3:
  - Form s = xp_al ± p (DW+TW+3 bits).
  - Shift right by SH = TW-1+scale with round-half-up: add 1<<(SH-1), then arithmetic shift.
  - If the result is outside [-2^(DW-1), 2^(DW-1)-1]:
    - SAT_EN=1: clamp to that bound.
    - SAT_EN=0: keep the low DW bits.
  - In either case ovf is set.
  - Real and imaginary parts, and yp and yq, are checked independently.
- ovf: set by any out-of-range result on a valid output; cleared by ovf_clr. If set and clear occur in the same cycle, set wins (ovf stays 1).
- Only in-range arithmetic is exact; no other exceptions.

Test Plan:
1. DW=TW=16, xp=(1000,0), xq=(2000,0), W=(16384,0), scale=0, inv=0 -> 3 cycles later out_vld=1, yp=(2000,0), yq=(0,0), ovf=0.
2. Same inputs with scale=1 -> yp=(1000,0), yq=(0,0). Then back-to-back samples alternating scale 0/1 every cycle -> outputs alternate correctly at 1/cycle with no bubbles.
3. xp=(1000,0), xq=(2000,0), W=(0,-16384) with inv=0 -> yp=(1000,-1000), yq=(1000,1000). With inv=1 -> yp=(1000,1000), yq=(1000,-1000).
4. xp=(30000,0), xq=(30000,0), W=(16384,0) with SAT_EN=1 -> yp_re=32767, yq_re=15000, ovf=1 and stays 1. Pulse ovf_clr with no overflowing sample -> ovf=0. Pulse ovf_clr with an overflowing output in the same cycle -> ovf=1.
5. Rounding: xp=(0,0), xq=(1,0), W=(16384,0), scale=0 -> yp_re=1 (0.5 rounds up), yq_re=0 (-0.5 rounds up to 0).
6. Reset mid-operation: three valid samples in flight, assert rst for 1 cycle -> out_vld, y*, ovf all 0 immediately (asynchronous). None of the three samples appears after release; the next in_vld emerges 3 cycles later.
